// File: rtl/ppu_bg_fetcher_if.sv
// VRAM read port and pixel stream handshake between the background fetcher and its neighbours.
interface ppu_bg_fetcher_if;
  logic        vram_en;
  logic [12:0] vram_addr;
  logic [7:0]  vram_dout;
  logic        pix_valid;
  logic [1:0]  pix_data;
  logic        pix_ready;

  modport master (
    output vram_en, vram_addr, pix_valid, pix_data,
    input  vram_dout, pix_ready
  );

  modport slave (
    input  vram_en, vram_addr, pix_valid, pix_data,
    output vram_dout, pix_ready
  );
endinterface

// File: rtl/ppu_bg_fetcher.sv
// Background tile fetcher: reads map, lo and hi bytes per tile from VRAM and streams
// one line of 2-bit pixels, discarding the fine-scroll bits of the first tile.
module ppu_bg_fetcher #(
  parameter int LINE_PIXELS = 160
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] scx,
  input  logic [7:0] scy,
  input  logic [7:0] ly,
  input  logic       bg_map_sel,
  input  logic       tile_data_sel,
  ppu_bg_fetcher_if.master bus,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(LINE_PIXELS + 1);
  localparam logic [CW-1:0] LAST_PIX = CW'(LINE_PIXELS - 1);

  typedef enum logic [2:0] {
    IDLE, MAP_REQ, MAP_CAP, LO_REQ, LO_CAP, HI_REQ, HI_CAP, PUSH
  } state_t;

  state_t        state_r, state_s;
  logic [7:0]    scx_r, scx_s, y_r, y_s;
  logic          map_sel_r, map_sel_s, data_sel_r, data_sel_s;
  logic [7:0]    tile_idx_r, tile_idx_s;
  logic [CW-1:0] pix_cnt_r, pix_cnt_s;
  logic [2:0]    bit_idx_r, bit_idx_s;
  logic [7:0]    tile_num_r, tile_num_s, lo_r, lo_s, hi_r, hi_s;
  logic          done_s, accept_s, discard_s, discard_next_s;
  logic [4:0]    col_s;
  logic [12:0]   map_addr_s, lo_addr_s, addr_next_s;

  logic          vram_en_r, pix_valid_r, busy_r, done_r;
  logic [12:0]   vram_addr_r;
  logic [1:0]    pix_data_r;

  // Row address of a tile's lo byte; signed mode is based at 0x1000 and wraps to 13 bits.
  function automatic logic [12:0] tile_row_addr(input logic [7:0] tile, input logic [2:0] row,
                                                input logic unsigned_mode);
    logic [12:0] off_s;
    off_s = {9'd0, row, 1'b0};
    if (unsigned_mode) begin
      tile_row_addr = {1'b0, tile, 4'd0} + off_s;
    end else begin
      tile_row_addr = 13'h1000 + {tile[7], tile, 4'd0} + off_s;
    end
  endfunction

  // Next-state, counter and capture logic
  always_comb begin
    state_s    = state_r;
    scx_s      = scx_r;
    y_s        = y_r;
    map_sel_s  = map_sel_r;
    data_sel_s = data_sel_r;
    tile_idx_s = tile_idx_r;
    pix_cnt_s  = pix_cnt_r;
    bit_idx_s  = bit_idx_r;
    tile_num_s = tile_num_r;
    lo_s       = lo_r;
    hi_s       = hi_r;
    done_s     = 1'b0;
    accept_s   = pix_valid_r & bus.pix_ready;
    discard_s  = (state_r == PUSH) && (tile_idx_r == 8'd0) && ((3'd7 - bit_idx_r) < scx_r[2:0]);
    case (state_r)
      IDLE: begin
        if (start) begin
          scx_s      = scx;
          y_s        = ly + scy;
          map_sel_s  = bg_map_sel;
          data_sel_s = tile_data_sel;
          tile_idx_s = 8'd0;
          pix_cnt_s  = '0;
          bit_idx_s  = 3'd7;
          state_s    = MAP_REQ;
        end else begin
          state_s = IDLE;
        end
      end
      MAP_REQ: state_s = MAP_CAP;
      MAP_CAP: begin
        tile_num_s = bus.vram_dout;
        state_s    = LO_REQ;
      end
      LO_REQ:  state_s = LO_CAP;
      LO_CAP: begin
        lo_s    = bus.vram_dout;
        state_s = HI_REQ;
      end
      HI_REQ:  state_s = HI_CAP;
      HI_CAP: begin
        hi_s      = bus.vram_dout;
        bit_idx_s = 3'd7;
        state_s   = PUSH;
      end
      PUSH: begin
        if (accept_s && (pix_cnt_r == LAST_PIX)) begin
          pix_cnt_s = pix_cnt_r + CW'(1);
          done_s    = 1'b1;
          state_s   = IDLE;
        end else if (accept_s || discard_s) begin
          if (accept_s) begin
            pix_cnt_s = pix_cnt_r + CW'(1);
          end else begin
            pix_cnt_s = pix_cnt_r;
          end
          if (bit_idx_r == 3'd0) begin
            tile_idx_s = tile_idx_r + 8'd1;
            state_s    = MAP_REQ;
          end else begin
            bit_idx_s = bit_idx_r - 3'd1;
          end
        end else begin
          state_s = PUSH;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next-state values
  always_comb begin
    col_s          = scx_s[7:3] + tile_idx_s[4:0];
    map_addr_s     = {2'b11, map_sel_s, y_s[7:3], col_s};
    lo_addr_s      = tile_row_addr(tile_num_s, y_s[2:0], data_sel_s);
    discard_next_s = (tile_idx_s == 8'd0) && ((3'd7 - bit_idx_s) < scx_s[2:0]);
    case (state_s)
      MAP_REQ, MAP_CAP: addr_next_s = map_addr_s;
      LO_REQ, LO_CAP:   addr_next_s = lo_addr_s;
      HI_REQ, HI_CAP:   addr_next_s = lo_addr_s + 13'd1;
      default:          addr_next_s = 13'd0;
    endcase
  end

  // State, captured bytes and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      scx_r       <= 8'd0;
      y_r         <= 8'd0;
      map_sel_r   <= 1'b0;
      data_sel_r  <= 1'b0;
      tile_idx_r  <= 8'd0;
      pix_cnt_r   <= '0;
      bit_idx_r   <= 3'd0;
      tile_num_r  <= 8'd0;
      lo_r        <= 8'd0;
      hi_r        <= 8'd0;
      vram_en_r   <= 1'b0;
      vram_addr_r <= 13'd0;
      pix_valid_r <= 1'b0;
      pix_data_r  <= 2'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      scx_r       <= scx_s;
      y_r         <= y_s;
      map_sel_r   <= map_sel_s;
      data_sel_r  <= data_sel_s;
      tile_idx_r  <= tile_idx_s;
      pix_cnt_r   <= pix_cnt_s;
      bit_idx_r   <= bit_idx_s;
      tile_num_r  <= tile_num_s;
      lo_r        <= lo_s;
      hi_r        <= hi_s;
      vram_en_r   <= (state_s == MAP_REQ) || (state_s == LO_REQ) || (state_s == HI_REQ);
      vram_addr_r <= addr_next_s;
      pix_valid_r <= (state_s == PUSH) && !discard_next_s;
      pix_data_r  <= (state_s == PUSH) ? {hi_s[bit_idx_s], lo_s[bit_idx_s]} : 2'd0;
      busy_r      <= (state_s != IDLE);
      done_r      <= done_s;
    end
  end

  assign bus.vram_en   = vram_en_r;
  assign bus.vram_addr = vram_addr_r;
  assign bus.pix_valid = pix_valid_r;
  assign bus.pix_data  = pix_data_r;
  assign busy          = busy_r;
  assign done          = done_r;

endmodule

// File: tb/tb_ppu_bg_fetcher.sv
// Scoreboard bench for ppu_bg_fetcher: a VRAM model, a reference line model filling
// expected address/pixel queues, and a negedge monitor comparing what the DUT presents.
module tb_ppu_bg_fetcher;
  localparam int NPIX = 160;

  logic clk, reset, start, bg_map_sel, tile_data_sel, busy, done;
  logic [7:0] scx, scy, ly;
  logic rand_ready;

  ppu_bg_fetcher_if bus ();

  ppu_bg_fetcher #(.LINE_PIXELS(NPIX)) dut (
    .clk(clk), .reset(reset), .start(start), .scx(scx), .scy(scy), .ly(ly),
    .bg_map_sel(bg_map_sel), .tile_data_sel(tile_data_sel), .bus(bus),
    .busy(busy), .done(done)
  );

  logic [7:0]  mem [0:8191];
  logic [12:0] exp_addr [$];
  logic [1:0]  exp_pix [$];
  logic [12:0] addr_hist [$];
  logic [1:0]  pix_hist [$];
  int tests = 0, fails = 0;
  int pix_total = 0, done_total = 0;
  int pix_base, done_base, addr_base;
  logic       prev_stall = 1'b0;
  logic [1:0] prev_data = 2'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Registered-read VRAM
  always @(posedge clk) begin
    if (bus.vram_en) bus.vram_dout <= mem[bus.vram_addr];
  end

  // Ready driver: constant 1 or pseudo-random
  initial begin
    bus.pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.pix_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every VRAM read and every accepted pixel
  always @(negedge clk) begin
    if (bus.vram_en) begin
      addr_hist.push_back(bus.vram_addr);
      if (exp_addr.size() == 0) check("addr_extra", {19'd0, bus.vram_addr}, 32'hFFFF);
      else check("vram_addr", {19'd0, bus.vram_addr}, {19'd0, exp_addr.pop_front()});
    end
    if (prev_stall) begin
      check("stall_valid", {31'd0, bus.pix_valid}, 32'd1);
      check("stall_data", {30'd0, bus.pix_data}, {30'd0, prev_data});
    end
    if (bus.pix_valid && bus.pix_ready) begin
      pix_total++;
      pix_hist.push_back(bus.pix_data);
      if (exp_pix.size() == 0) check("pix_extra", {30'd0, bus.pix_data}, 32'hFF);
      else check("pix_data", {30'd0, bus.pix_data}, {30'd0, exp_pix.pop_front()});
    end
    if (done) begin
      done_total++;
      check("done_valid", {31'd0, bus.pix_valid}, 32'd0);
      check("done_busy", {31'd0, busy}, 32'd0);
    end
    prev_stall = bus.pix_valid && !bus.pix_ready;
    prev_data  = bus.pix_data;
  end

  // Reference line model working in plain integer arithmetic
  task automatic model_line(input int sx, input int sy, input int l, input bit ms, input bit ds);
    int y, npix, t, col, maddr, tn, la;
    logic [7:0] lo, hi;
    y = (l + sy) % 256;
    npix = 0;
    t = 0;
    while (npix < NPIX) begin
      col = ((sx / 8) + t) % 32;
      maddr = (ms ? 'h1C00 : 'h1800) + (y / 8) * 32 + col;
      tn = int'(mem[maddr]);
      if (ds) la = tn * 16 + (y % 8) * 2;
      else la = ('h1000 + ((tn >= 128) ? tn - 256 : tn) * 16 + (y % 8) * 2) & 'h1FFF;
      exp_addr.push_back(13'(maddr));
      exp_addr.push_back(13'(la));
      exp_addr.push_back(13'((la + 1) & 'h1FFF));
      lo = mem[la];
      hi = mem[(la + 1) & 'h1FFF];
      for (int b = 7; b >= 0; b--) begin
        if (npix < NPIX && !(t == 0 && (7 - b) < (sx % 8))) begin
          exp_pix.push_back({hi[b], lo[b]});
          npix++;
        end
      end
      t++;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 8192; i++) mem[i] = 8'd0;
  endtask

  task automatic set_bases();
    pix_base  = pix_total;
    done_base = done_total;
    addr_base = addr_hist.size();
  endtask

  // Sets inputs, loads the scoreboard, pulses start, then scrambles inputs after the start edge
  task automatic start_line(input logic [7:0] sx, input logic [7:0] sy, input logic [7:0] l,
                            input logic ms, input logic ds);
    scx = sx; scy = sy; ly = l; bg_map_sel = ms; tile_data_sel = ds;
    model_line(int'(sx), int'(sy), int'(l), ms, ds);
    set_bases();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    scx = ~sx; scy = ~sy; ly = ~l; bg_map_sel = ~ms; tile_data_sel = ~ds;
  endtask

  // Hand-computed first-tile timing for the map byte 0x01 / 0xF0 / 0xCC line
  task automatic check_timing33();
    @(negedge clk);
    check("t1_en", {31'd0, bus.vram_en}, 32'd1);
    check("t1_addr", {19'd0, bus.vram_addr}, 32'h1800);
    check("t1_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("t2_en", {31'd0, bus.vram_en}, 32'd0);
    check("t2_addr_hold", {19'd0, bus.vram_addr}, 32'h1800);
    @(negedge clk);
    check("t3_en", {31'd0, bus.vram_en}, 32'd1);
    check("t3_addr", {19'd0, bus.vram_addr}, 32'h0010);
    @(negedge clk);
    check("t4_en", {31'd0, bus.vram_en}, 32'd0);
    @(negedge clk);
    check("t5_en", {31'd0, bus.vram_en}, 32'd1);
    check("t5_addr", {19'd0, bus.vram_addr}, 32'h0011);
    @(negedge clk);
    check("t6_valid", {31'd0, bus.pix_valid}, 32'd0);
    @(negedge clk);
    check("t7_valid", {31'd0, bus.pix_valid}, 32'd1);
    check("t7_data", {30'd0, bus.pix_data}, 32'd3);
  endtask

  task automatic finish_line(input string nm);
    int k;
    k = 0;
    while (done_total == done_base && k < 4000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 4000) check({nm, "_timeout"}, 32'd1, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check({nm, "_done_cnt"}, done_total - done_base, 32'd1);
    check({nm, "_pixels"}, pix_total - pix_base, NPIX);
    check({nm, "_busy"}, {31'd0, busy}, 32'd0);
    check({nm, "_addr_left"}, exp_addr.size(), 32'd0);
    check({nm, "_pix_left"}, exp_pix.size(), 32'd0);
  endtask

  task automatic setup33();
    clear_mem();
    mem[13'h1800] = 8'h01;
    mem[13'h0010] = 8'hF0;
    mem[13'h0011] = 8'hCC;
  endtask

  initial begin
    rand_ready = 1'b0;
    reset = 1'b1; start = 1'b1;
    scx = 8'd0; scy = 8'd0; ly = 8'd0; bg_map_sel = 1'b0; tile_data_sel = 1'b1;
    clear_mem();

    // Reset held two cycles with start high
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_en", {31'd0, bus.vram_en}, 32'd0);
    check("rst_addr", {19'd0, bus.vram_addr}, 32'd0);
    check("rst_valid", {31'd0, bus.pix_valid}, 32'd0);
    check("rst_data", {30'd0, bus.pix_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1 reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // Basic unsigned line
    setup33();
    start_line(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    check_timing33();
    finish_line("basic");

    // Signed tile addressing, ly=5
    clear_mem();
    mem[13'h1800] = 8'h80;
    mem[13'h1801] = 8'h7F;
    start_line(8'h00, 8'h00, 8'h05, 1'b0, 1'b0);
    finish_line("signed");
    check("signed_lo80", {19'd0, addr_hist[addr_base + 1]}, 32'h080A);
    check("signed_hi80", {19'd0, addr_hist[addr_base + 2]}, 32'h080B);
    check("signed_lo7f", {19'd0, addr_hist[addr_base + 4]}, 32'h17FA);

    // Fine scroll and column wrap on map 1
    clear_mem();
    mem[13'h1C1F] = 8'h02;
    mem[13'h0020] = 8'h10;
    mem[13'h0021] = 8'h00;
    start_line(8'hFB, 8'h00, 8'h00, 1'b1, 1'b1);
    finish_line("scroll");
    check("scroll_map0", {19'd0, addr_hist[addr_base]}, 32'h1C1F);
    check("scroll_map1", {19'd0, addr_hist[addr_base + 3]}, 32'h1C00);
    check("scroll_first_pix", {30'd0, pix_hist[pix_base]}, 32'd1);

    // Random back-pressure over patterned VRAM
    for (int i = 0; i < 8192; i++) mem[i] = 8'((i * 37 + 11) & 255);
    rand_ready = 1'b1;
    start_line(8'h0D, 8'h13, 8'h22, 1'b0, 1'b0);
    finish_line("stall");
    rand_ready = 1'b0;
    @(posedge clk);

    // Reset on the third PUSH cycle, restart on the first cycle after reset
    setup33();
    start_line(8'h00, 8'h00, 8'h00, 1'b0, 1'b1);
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; start = 1'b1;
    scx = 8'h00; scy = 8'h00; ly = 8'h00; bg_map_sel = 1'b0; tile_data_sel = 1'b1;
    exp_addr.delete();
    exp_pix.delete();
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_en", {31'd0, bus.vram_en}, 32'd0);
    check("abort_valid", {31'd0, bus.pix_valid}, 32'd0);
    check("abort_done", done_total - done_base, 32'd0);
    check("abort_pixels", pix_total - pix_base, 32'd3);
    model_line(0, 0, 0, 1'b0, 1'b1);
    set_bases();
    @(posedge clk); #1 start = 1'b0;
    scx = 8'h55; ly = 8'h33;
    check_timing33();
    finish_line("restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
